// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: two-entry (main + skid) instruction buffer between
// fetch and execute, halt parking with resume, flush, and a wrapping count of
// issued instructions.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Fetch side: accept = i_fetchValid & o_fetchReady. Execute side:
// issue = o_decValid & i_execReady. o_fetchReady is a register that depends
// only on state, so there is no combinational path from i_execReady to it.
module decode_issue_ctrl #(
    parameter int          CNT_W      = 16,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fetchValid,
    input  logic [15:0]      i_fetchInstr,
    output logic             o_fetchReady,
    output logic             o_decValid,
    input  logic             i_execReady,
    output logic [15:0]      o_instr,
    output logic [3:0]       o_instrOpcode,
    output logic [7:0]       o_instrImm,
    input  logic             i_flush,
    input  logic             i_resume,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_issueCnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        SKID   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      main_q, main_d;
    logic [15:0]      skid_q, skid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic issue;
    logic halt_issue;
    logic dec_valid;

    assign dec_valid  = (state_q == FULL) || (state_q == SKID);
    assign accept     = i_fetchValid & ready_q;
    assign issue      = dec_valid & i_execReady;
    assign halt_issue = issue && (main_q == HALT_INSTR);

    // Next-state and buffer data: halt issue beats flush beats normal flow.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (halt_issue) begin
            // Anything younger than the halt (skid or same-cycle accept) is dropped.
            state_d = HALTED;
        end else if (i_flush && state_q != HALTED) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = i_fetchInstr;
                    end
                end
                FULL: begin
                    if (accept && issue) begin
                        main_d = i_fetchInstr;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = i_fetchInstr;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (issue) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                HALTED: begin
                    if (i_resume) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Fetch may send whenever the next state still has a free slot.
        ready_d = (state_d == EMPTY) || (state_d == FULL);
    end

    // State, buffer and fetch-ready registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    // Issue counter; wraps naturally and survives flush and halt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (issue) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_fetchReady  = ready_q;
    assign o_decValid    = dec_valid;
    assign o_instr       = main_q;
    assign o_instrOpcode = main_q[15:12];
    assign o_instrImm    = main_q[7:0];
    assign o_halted      = (state_q == HALTED);
    assign o_issueCnt    = cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: streaming, backpressure/skid, halt and
// resume, flush, counter wrap and reset while halted.
module tb_decode_issue_ctrl;

    localparam int CNT_W = 4;

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_FULL   = 2'd1;
    localparam logic [1:0] S_SKID   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic             clk;
    logic             rst;
    logic             fetch_valid;
    logic [15:0]      fetch_instr;
    logic             fetch_ready;
    logic             dec_valid;
    logic             exec_ready;
    logic [15:0]      instr;
    logic [3:0]       opcode;
    logic [7:0]       imm;
    logic             flush;
    logic             resume;
    logic             halted;
    logic [CNT_W-1:0] issue_cnt;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    decode_issue_ctrl #(.CNT_W(CNT_W), .HALT_INSTR(16'hFFFF)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fetchValid (fetch_valid),
        .i_fetchInstr (fetch_instr),
        .o_fetchReady (fetch_ready),
        .o_decValid   (dec_valid),
        .i_execReady  (exec_ready),
        .o_instr      (instr),
        .o_instrOpcode(opcode),
        .o_instrImm   (imm),
        .i_flush      (flush),
        .i_resume     (resume),
        .o_halted     (halted),
        .o_issueCnt   (issue_cnt),
        .o_state      (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0;
        fetch_instr = 16'h0000;
        exec_ready  = 1'b0;
        flush       = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (state !== S_EMPTY) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, S_EMPTY); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", issue_cnt); end
    endtask

    task automatic test_streaming();
        logic [15:0] words [3];
        logic [3:0]  ops   [3];
        logic [7:0]  imms  [3];
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        ops   = '{4'h1, 4'h5, 4'h9};
        imms  = '{8'h34, 8'h78, 8'hBC};
        exec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = words[i];
            step();
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", i, dec_valid); end
            checks++; if (instr !== words[i]) begin errors++; $display("FAIL stream_instr%0d got %h exp %h", i, instr, words[i]); end
            checks++; if (opcode !== ops[i]) begin errors++; $display("FAIL stream_opcode%0d got %h exp %h", i, opcode, ops[i]); end
            checks++; if (imm !== imms[i]) begin errors++; $display("FAIL stream_imm%0d got %h exp %h", i, imm, imms[i]); end
            checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", i, fetch_ready); end
            checks++; if (issue_cnt !== 4'(i)) begin errors++; $display("FAIL stream_cnt%0d got %0d exp %0d", i, issue_cnt, i); end
        end
        fetch_valid = 1'b0;
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b exp 0", dec_valid); end
        checks++; if (issue_cnt !== 4'd3) begin errors++; $display("FAIL stream_cnt_final got %0d exp 3", issue_cnt); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL stream_drain_ready got %b exp 1", fetch_ready); end
    endtask

    task automatic test_backpressure();
        exec_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hA001;
        step();
        checks++; if (state !== S_FULL) begin errors++; $display("FAIL bp_full_state got %0d exp %0d", state, S_FULL); end
        fetch_instr = 16'hA002;
        step();
        checks++; if (state !== S_SKID) begin errors++; $display("FAIL bp_skid_state got %0d exp %0d", state, S_SKID); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got %b exp 0", fetch_ready); end
        checks++; if (instr !== 16'hA001) begin errors++; $display("FAIL bp_skid_instr got %h exp A001", instr); end
        // A word offered while not ready must not be taken.
        fetch_instr = 16'hA003;
        step();
        checks++; if (state !== S_SKID) begin errors++; $display("FAIL bp_hold_state got %0d exp %0d", state, S_SKID); end
        checks++; if (instr !== 16'hA001) begin errors++; $display("FAIL bp_hold_instr got %h exp A001", instr); end
        fetch_valid = 1'b0;
        exec_ready  = 1'b1;
        step();
        checks++; if (instr !== 16'hA002) begin errors++; $display("FAIL bp_second_instr got %h exp A002", instr); end
        checks++; if (state !== S_FULL) begin errors++; $display("FAIL bp_drain_state got %0d exp %0d", state, S_FULL); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready got %b exp 1", fetch_ready); end
        checks++; if (issue_cnt !== 4'd4) begin errors++; $display("FAIL bp_cnt_mid got %0d exp 4", issue_cnt); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got %b exp 0", dec_valid); end
        checks++; if (issue_cnt !== 4'd5) begin errors++; $display("FAIL bp_cnt_end got %0d exp 5", issue_cnt); end
        exec_ready = 1'b0;
    endtask

    task automatic test_halt();
        // Resume outside HALTED is ignored.
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (state !== S_EMPTY) begin errors++; $display("FAIL halt_resume_ignored got %0d exp %0d", state, S_EMPTY); end
        exec_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hFFFF;
        step();
        fetch_instr = 16'h2222;
        step();
        checks++; if (state !== S_SKID) begin errors++; $display("FAIL halt_setup_state got %0d exp %0d", state, S_SKID); end
        fetch_valid = 1'b0;
        exec_ready  = 1'b1;
        step();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b exp 1", halted); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL halt_dec_valid got %b exp 0", dec_valid); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b exp 0", fetch_ready); end
        checks++; if (issue_cnt !== 4'd6) begin errors++; $display("FAIL halt_cnt got %0d exp 6", issue_cnt); end
        // Parked: flush, fetch and execute activity change nothing.
        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 16'h3333;
        step();
        step();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        checks++; if (state !== S_HALTED) begin errors++; $display("FAIL halt_park_state got %0d exp %0d", state, S_HALTED); end
        checks++; if (issue_cnt !== 4'd6) begin errors++; $display("FAIL halt_park_cnt got %0d exp 6", issue_cnt); end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume_halted got %b exp 0", halted); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL halt_resume_ready got %b exp 1", fetch_ready); end
        checks++; if (state !== S_EMPTY) begin errors++; $display("FAIL halt_resume_state got %0d exp %0d", state, S_EMPTY); end
        // Halt issue together with flush still parks.
        exec_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hFFFF;
        step();
        fetch_valid = 1'b0;
        flush       = 1'b1;
        exec_ready  = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (state !== S_HALTED) begin errors++; $display("FAIL halt_flush_state got %0d exp %0d", state, S_HALTED); end
        checks++; if (issue_cnt !== 4'd7) begin errors++; $display("FAIL halt_flush_cnt got %0d exp 7", issue_cnt); end
        resume     = 1'b1;
        exec_ready = 1'b0;
        step();
        resume = 1'b0;
    endtask

    task automatic test_flush();
        exec_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hB001;
        step();
        fetch_instr = 16'hB002;
        step();
        checks++; if (state !== S_SKID) begin errors++; $display("FAIL flush_setup_state got %0d exp %0d", state, S_SKID); end
        fetch_valid = 1'b0;
        flush       = 1'b1;
        exec_ready  = 1'b1;
        step();
        checks++; if (state !== S_EMPTY) begin errors++; $display("FAIL flush_state got %0d exp %0d", state, S_EMPTY); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_dec_valid got %b exp 0", dec_valid); end
        checks++; if (issue_cnt !== 4'd8) begin errors++; $display("FAIL flush_cnt got %0d exp 8", issue_cnt); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", fetch_ready); end
        // A word accepted in the flush cycle is dropped.
        exec_ready  = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hB003;
        step();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_drop got %b exp 0", dec_valid); end
    endtask

    task automatic test_wrap_and_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exec_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 16'h4000 + 16'(i);
            step();
        end
        fetch_valid = 1'b0;
        step();
        checks++; if (issue_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got %0d exp 1", issue_cnt); end
        fetch_valid = 1'b1;
        fetch_instr = 16'hFFFF;
        step();
        fetch_valid = 1'b0;
        step();
        checks++; if (state !== S_HALTED) begin errors++; $display("FAIL wrap_halt_state got %0d exp %0d", state, S_HALTED); end
        // Reset beats resume, flush and fetch while parked.
        rst         = 1'b1;
        resume      = 1'b1;
        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 16'h5555;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++; if (state !== S_EMPTY) begin errors++; $display("FAIL rst_halt_state got %0d exp %0d", state, S_EMPTY); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halt_halted got %b exp 0", halted); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_halt_ready got %b exp 1", fetch_ready); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rst_halt_dec_valid got %b exp 0", dec_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_halt_instr got %h exp 0000", instr); end
        checks++; if (issue_cnt !== 4'd0) begin errors++; $display("FAIL rst_halt_cnt got %0d exp 0", issue_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_halt();
        test_flush();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
